// File: rtl/lb_pkg.sv
// Shared types and helpers for the local-bus splitter.
// Pure definitions: no latency, no backpressure.
// Decode maps an upstream address onto a slave index plus a hit flag.
package lb_pkg;

    typedef enum logic [2:0] {IDLE, WR, RD, WACK, RACK} lb_state_t;

    localparam logic [31:0] LB_ERR_RDATA = 32'hBADBAD00;
    localparam int          LB_IDX_W     = 4;

    typedef struct packed {
        logic                hit;
        logic [LB_IDX_W-1:0] idx;
    } lb_dec_t;

    // Every bit above the slave window takes part in the range check, so stray
    // high address bits always produce a miss rather than aliasing onto a slave.
    function automatic lb_dec_t lb_decode(input logic [63:0] addr,
                                          input int          slave_aw,
                                          input int          n_slaves);
        logic [63:0] upper;
        lb_dec_t     d;
        upper = addr >> slave_aw;
        d.hit = (upper < 64'(n_slaves));
        d.idx = upper[LB_IDX_W-1:0];
        return d;
    endfunction

endpackage

// File: rtl/lb_timeout_cnt.sv
// Saturating wait timer that flags expiry one count before TIMEOUT.
// Latency: expired is combinational from the registered count.
// Backpressure: none; TIMEOUT=0 disables expiry entirely.
module lb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, clear, enable};
            assign expired   = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && cnt != CW'(TIMEOUT)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expired = enable && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/lb_splitter.sv
// Local-bus fan-out: decodes the address and forwards one request at a time to N slaves.
// Latency: ack at T+2 for a zero-wait slave, T+1 on a decode miss; request path fully registered.
// Backpressure: upstream holds wen/ren until acked; slave stalls are bounded by TIMEOUT.
module lb_splitter
    import lb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                N_SLAVES  = 2,
    parameter int                SLAVE_AW  = 12,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(LB_ERR_RDATA),
    parameter int                STRB_W    = DATA_W / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [STRB_W-1:0]            wstrb,
    input  logic                         wen,
    output logic                         wready,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic                         ren,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    output logic [SLAVE_AW-1:0]          m_waddr,
    output logic [DATA_W-1:0]            m_wdata,
    output logic [STRB_W-1:0]            m_wstrb,
    output logic [N_SLAVES-1:0]          m_wen,
    input  logic [N_SLAVES-1:0]          m_wready,
    output logic [SLAVE_AW-1:0]          m_raddr,
    output logic [N_SLAVES-1:0]          m_ren,
    input  logic [N_SLAVES*DATA_W-1:0]   m_rdata,
    input  logic [N_SLAVES-1:0]          m_rvalid,
    output logic                         err
);

    lb_state_t   state;
    lb_dec_t     wdec;
    lb_dec_t     rdec;
    logic        tmr_clear;
    logic        expired;
    logic        sel_wready;
    logic        sel_rvalid;
    logic [DATA_W-1:0] sel_rdata;

    assign wdec = lb_decode(64'(waddr), SLAVE_AW, N_SLAVES);
    assign rdec = lb_decode(64'(raddr), SLAVE_AW, N_SLAVES);

    // The registered one-hot strobe doubles as the latched slave index, so
    // responses from unselected slaves are masked out for free.
    assign sel_wready = |(m_wready & m_wen);
    assign sel_rvalid = |(m_rvalid & m_ren);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (m_ren[i]) begin
                sel_rdata = sel_rdata | m_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmr_clear = !(state == WR || state == RD);

    lb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (!tmr_clear),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            m_wen   <= '0;
            m_raddr <= '0;
            m_ren   <= '0;
        end else begin
            wready <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (wen) begin
                        m_waddr <= waddr[SLAVE_AW-1:0];
                        m_wdata <= wdata;
                        m_wstrb <= wstrb;
                        if (wdec.hit) begin
                            m_wen <= N_SLAVES'(1) << wdec.idx;
                            state <= WR;
                        end else begin
                            wready <= 1'b1;
                            err    <= 1'b1;
                            state  <= WACK;
                        end
                    end else if (ren) begin
                        m_raddr <= raddr[SLAVE_AW-1:0];
                        if (rdec.hit) begin
                            m_ren <= N_SLAVES'(1) << rdec.idx;
                            state <= RD;
                        end else begin
                            rvalid <= 1'b1;
                            rdata  <= ERR_RDATA;
                            err    <= 1'b1;
                            state  <= RACK;
                        end
                    end
                end
                WR: begin
                    // A response arriving on the expiry cycle still counts as success.
                    if (sel_wready || expired) begin
                        m_wen  <= '0;
                        wready <= 1'b1;
                        err    <= !sel_wready;
                        state  <= WACK;
                    end
                end
                RD: begin
                    if (sel_rvalid || expired) begin
                        m_ren  <= '0;
                        rvalid <= 1'b1;
                        rdata  <= sel_rvalid ? sel_rdata : ERR_RDATA;
                        err    <= !sel_rvalid;
                        state  <= RACK;
                    end
                end
                WACK:    state <= IDLE;
                RACK:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_splitter.sv
// Directed bench for lb_splitter with two behavioural slaves.
// Slaves: write ready unless blocked, read valid after a programmable wait.
// Upstream master drops its request on the cycle the ack is seen.
module tb_lb_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] waddr = '0, wdata = '0, raddr = '0;
    logic [3:0]  wstrb = '0;
    logic        wen = 1'b0, ren = 1'b0;
    logic        wready, rvalid, err;
    logic [31:0] rdata;
    logic [11:0] m_waddr, m_raddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_wen, m_ren, m_wready, m_rvalid;
    logic [63:0] m_rdata;

    logic [1:0]  wr_block = 2'b00;
    int          rd_wait [2] = '{0, 0};
    int          wcnt [2] = '{0, 0};
    logic [31:0] rd_data0 = '0, rd_data1 = '0;

    int n_vec = 0, n_bad = 0;
    int n_err = 0, n_wready = 0, n_rvalid = 0;

    always #5 clk = ~clk;

    lb_splitter dut (
        .clk      (clk),
        .rst      (rst),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wen      (wen),
        .wready   (wready),
        .raddr    (raddr),
        .ren      (ren),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .m_waddr  (m_waddr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_wen    (m_wen),
        .m_wready (m_wready),
        .m_raddr  (m_raddr),
        .m_ren    (m_ren),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .err      (err)
    );

    assign m_wready = m_wen & ~wr_block;
    assign m_rdata  = {rd_data1, rd_data0};
    assign m_rvalid[0] = m_ren[0] && (wcnt[0] >= rd_wait[0]);
    assign m_rvalid[1] = m_ren[1] && (wcnt[1] >= rd_wait[1]);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!m_ren[i])          wcnt[i] <= 0;
            else if (!m_rvalid[i])  wcnt[i] <= wcnt[i] + 1;
        end
        n_err    <= n_err + int'(err);
        n_wready <= n_wready + int'(wready);
        n_rvalid <= n_rvalid + int'(rvalid);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Captured slave-side view of the most recent transaction.
    logic [1:0]  cap_wen, cap_ren;
    logic [11:0] cap_waddr, cap_raddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    int          wen_cyc, ren_cyc;

    // Called #1 after a clock edge; latencies count edges from the request cycle.
    task automatic xact(input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input bit dr, input logic [31:0] ra,
                        output int wlat, output int rlat, output logic [31:0] rd);
        int cyc;
        bit wdone, rdone;
        wlat = -1; rlat = -1; rd = '0; cyc = 0;
        cap_wen = '0; cap_ren = '0; cap_waddr = '0; cap_raddr = '0;
        cap_wdata = '0; cap_wstrb = '0; wen_cyc = 0; ren_cyc = 0;
        wdone = !dw; rdone = !dr;
        waddr = wa; wdata = wd; wstrb = ws; wen = dw;
        raddr = ra; ren = dr;
        while (!(wdone && rdone) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (m_wen != 0) begin
                wen_cyc++;
                if (cap_wen == 0) begin
                    cap_wen = m_wen; cap_waddr = m_waddr;
                    cap_wdata = m_wdata; cap_wstrb = m_wstrb;
                end
            end
            if (m_ren != 0) begin
                ren_cyc++;
                if (cap_ren == 0) begin
                    cap_ren = m_ren; cap_raddr = m_raddr;
                end
            end
            if (wready && !wdone) begin wlat = cyc; wdone = 1'b1; wen = 1'b0; end
            if (rvalid && !rdone) begin rlat = cyc; rd = rdata; rdone = 1'b1; ren = 1'b0; end
        end
        wen = 1'b0; ren = 1'b0;
        chk("xact_done", {62'b0, wdone, rdone}, 64'h3);
    endtask

    initial begin
        int wl, rl, e0, w0, r0;
        logic [31:0] rd;

        // Reset state
        #1;
        chk("rst_outs", {wready, rvalid, rdata, err, m_wen, m_ren, m_waddr, m_raddr}, 64'h0);
        idle(3);
        #2 rst = 1'b1;
        idle(2);
        chk("post_rst_outs", {wready, rvalid, rdata, err, m_wen, m_ren, m_wdata}, 64'h0);

        // 1: write to slave1
        e0 = n_err; w0 = n_wready;
        xact(1, 32'h1008, 32'hcafebabe, 4'b0110, 0, 0, wl, rl, rd);
        idle(2);
        chk("t1_m_wen", cap_wen, 2'b10);
        chk("t1_m_waddr", cap_waddr, 12'h008);
        chk("t1_m_wdata", cap_wdata, 32'hcafebabe);
        chk("t1_m_wstrb", cap_wstrb, 4'b0110);
        chk("t1_wlat", wl, 2);
        chk("t1_wready_pulses", n_wready - w0, 1);
        chk("t1_err", n_err - e0, 0);

        // wstrb=0 still forwarded to slave0
        xact(1, 32'h0000, 32'h12345678, 4'b0000, 0, 0, wl, rl, rd);
        idle(2);
        chk("strb0_m_wen", cap_wen, 2'b01);
        chk("strb0_m_wstrb", cap_wstrb, 4'b0000);

        // 2: read slave0 with 5 wait cycles
        rd_wait[0] = 5; rd_data0 = 32'hc0debabe; e0 = n_err;
        xact(0, 0, 0, 0, 1, 32'h0014, wl, rl, rd);
        chk("t2_m_ren", cap_ren, 2'b01);
        chk("t2_m_raddr", cap_raddr, 12'h014);
        chk("t2_rdata", rd, 32'hc0debabe);
        chk("t2_rlat", rl, 7);
        chk("t2_ren_cycles", ren_cyc, 6);
        idle(1);
        chk("t2_rdata_clr", {rvalid, rdata}, 0);
        idle(1);
        chk("t2_err", n_err - e0, 0);

        // 3: decode misses on write and read
        e0 = n_err;
        xact(1, 32'h80000004, 32'h55aa55aa, 4'hf, 0, 0, wl, rl, rd);
        chk("t3_wlat", wl, 1);
        chk("t3_no_wen", wen_cyc, 0);
        idle(2);
        xact(0, 0, 0, 0, 1, 32'h2000, wl, rl, rd);
        chk("t3_rlat", rl, 1);
        chk("t3_rdata", rd, 32'hBADBAD00);
        chk("t3_no_ren", ren_cyc, 0);
        idle(2);
        chk("t3_err_pulses", n_err - e0, 2);

        // 4: slave1 stalls writes; timeout after 255 cycles
        wr_block[1] = 1'b1; e0 = n_err; w0 = n_wready;
        xact(1, 32'h1000, 32'hdeadbeef, 4'hf, 0, 0, wl, rl, rd);
        chk("t4_wen_cycles", wen_cyc, 255);
        chk("t4_wlat", wl, 256);
        chk("t4_m_wen_drop", m_wen, 2'b00);
        idle(2);
        chk("t4_err_pulses", n_err - e0, 1);
        chk("t4_wready_pulses", n_wready - w0, 1);
        rd_wait[0] = 0; rd_data0 = 32'h0badf00d; e0 = n_err;
        xact(0, 0, 0, 0, 1, 32'h0010, wl, rl, rd);
        chk("t4_next_rdata", rd, 32'h0badf00d);
        chk("t4_next_rlat", rl, 2);
        idle(2);
        chk("t4_next_err", n_err - e0, 0);
        wr_block[1] = 1'b0;

        // 5: simultaneous write (slave0) and read (slave1)
        rd_data1 = 32'h11112222; e0 = n_err; w0 = n_wready; r0 = n_rvalid;
        xact(1, 32'h0004, 32'ha5a5a5a5, 4'hf, 1, 32'h1008, wl, rl, rd);
        chk("t5_wlat", wl, 2);
        chk("t5_rlat", rl, 5);
        chk("t5_rdata", rd, 32'h11112222);
        chk("t5_m_wen", cap_wen, 2'b01);
        chk("t5_m_ren", cap_ren, 2'b10);
        idle(3);
        chk("t5_ack_counts", {n_wready - w0, n_rvalid - r0, n_err - e0}, {32'd1, 32'd1, 32'd0});

        // 6: async reset while in RD
        rd_wait[0] = 50; rd_data0 = 32'hc0debabe;
        raddr = 32'h0014; ren = 1'b1;
        idle(3);
        chk("t6_in_rd", m_ren, 2'b01);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_outs", {wready, rvalid, rdata, err, m_wen, m_ren, m_raddr}, 64'h0);
        ren = 1'b0;
        idle(2);
        #2 rst = 1'b1;
        idle(2);
        chk("t6_idle_outs", {m_ren, m_wen, rvalid, wready}, 64'h0);
        rd_wait[0] = 0;
        xact(0, 0, 0, 0, 1, 32'h0014, wl, rl, rd);
        chk("t6_rdata", rd, 32'hc0debabe);
        chk("t6_rlat", rl, 2);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
